// File: rtl/mvm_host_ctrl.sv
// mvm_host_ctrl: host-side initiator for the mvm_k_b matrix-vector core.
// Stages one command's operand words, replays them to the core as gap-free
// load bursts, pulses start, captures the k serial results and hands them
// out over a valid/ready result stream.
module mvm_host_ctrl #(
   parameter int k       = 8,
   parameter int b       = 8,
   parameter int timeout = 4096
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [1:0]            cmd_mode,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic signed [b-1:0]   in_data,
   output logic                  loadMatrix,
   output logic                  loadVector,
   output logic                  start,
   output logic signed [b-1:0]   data_in,
   input  logic                  done,
   input  logic signed [2*b-1:0] data_out,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic signed [2*b-1:0] res_data,
   output logic                  res_last,
   output logic                  busy,
   output logic                  err
);

   localparam int NW = k*k + k;
   localparam int CW = $clog2(NW + 1);
   localparam int TW = $clog2(timeout);
   localparam int RW = $clog2(k);
   localparam logic [CW-1:0] N_ALL  = CW'(NW);
   localparam logic [CW-1:0] N_MAT  = CW'(k*k);
   localparam logic [CW-1:0] N_VEC  = CW'(k);
   localparam logic [TW-1:0] T_LAST = TW'(timeout - 2);
   localparam logic [RW-1:0] R_LAST = RW'(k - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_FILL, S_LOAD1, S_STREAM1, S_LOAD2, S_STREAM2,
      S_START, S_WAIT, S_CAPTURE, S_DRAIN
   } state_t;

   state_t                state_q, state_d;
   logic [1:0]            mode_q, mode_d;
   logic [CW-1:0]         wr_cnt_q, wr_cnt_d;
   logic [CW-1:0]         rd_idx_q, rd_idx_d;
   logic [TW-1:0]         wait_cnt_q, wait_cnt_d;
   logic [RW-1:0]         cap_cnt_q, cap_cnt_d;
   logic [RW-1:0]         drn_idx_q, drn_idx_d;
   logic                  load_matrix_q, load_matrix_d;
   logic                  load_vector_q, load_vector_d;
   logic                  start_q, start_d;
   logic                  err_q, err_d;
   logic signed [b-1:0]   data_in_q, data_in_d;
   logic signed [b-1:0]   stage_q [NW];
   logic signed [2*b-1:0] res_buf_q [k];
   logic                  stage_we, res_we;
   logic                  mat_first, two_phase;
   logic [CW-1:0]         n_words, n_first;

   // Decode the latched mode into burst order and word counts.
   always_comb begin
      mat_first = (mode_q == 2'd0) || (mode_q == 2'd2);
      two_phase = !mode_q[1];
      case (mode_q)
         2'd2:    n_words = N_MAT;
         2'd3:    n_words = N_VEC;
         default: n_words = N_ALL;
      endcase
      n_first = mat_first ? N_MAT : N_VEC;
   end

   // Next-state logic; core-side outputs are derived from the next state so they leave a flop.
   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      wr_cnt_d   = wr_cnt_q;
      rd_idx_d   = rd_idx_q;
      wait_cnt_d = wait_cnt_q;
      cap_cnt_d  = cap_cnt_q;
      drn_idx_d  = drn_idx_q;
      err_d      = 1'b0;
      data_in_d  = '0;
      stage_we   = 1'b0;
      res_we     = 1'b0;
      case (state_q)
         S_IDLE: begin
            wr_cnt_d = '0;
            rd_idx_d = '0;
            if (cmd_valid) begin
               mode_d  = cmd_mode;
               state_d = S_FILL;
            end
         end
         S_FILL: begin
            if (in_valid) begin
               stage_we = 1'b1;
               wr_cnt_d = wr_cnt_q + CW'(1);
               if (wr_cnt_q == n_words - CW'(1)) state_d = S_LOAD1;
            end
         end
         S_LOAD1, S_LOAD2: begin
            // rd_idx_q always points at the next staged word to present.
            data_in_d = stage_q[rd_idx_q];
            rd_idx_d  = rd_idx_q + CW'(1);
            state_d   = (state_q == S_LOAD1) ? S_STREAM1 : S_STREAM2;
         end
         S_STREAM1: begin
            if (rd_idx_q == n_first) begin
               state_d = two_phase ? S_LOAD2 : S_START;
            end else begin
               data_in_d = stage_q[rd_idx_q];
               rd_idx_d  = rd_idx_q + CW'(1);
            end
         end
         S_STREAM2: begin
            if (rd_idx_q == n_words) begin
               state_d = S_START;
            end else begin
               data_in_d = stage_q[rd_idx_q];
               rd_idx_d  = rd_idx_q + CW'(1);
            end
         end
         S_START: begin
            wait_cnt_d = '0;
            state_d    = S_WAIT;
         end
         S_WAIT: begin
            // The abort lands err exactly timeout cycles after the start pulse.
            if (done) begin
               cap_cnt_d = '0;
               state_d   = S_CAPTURE;
            end else if (wait_cnt_q == T_LAST) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               wait_cnt_d = wait_cnt_q + TW'(1);
            end
         end
         S_CAPTURE: begin
            res_we = 1'b1;
            if (cap_cnt_q == R_LAST) begin
               drn_idx_d = '0;
               state_d   = S_DRAIN;
            end else begin
               cap_cnt_d = cap_cnt_q + RW'(1);
            end
         end
         S_DRAIN: begin
            if (res_ready) begin
               if (drn_idx_q == R_LAST) state_d = S_IDLE;
               else                     drn_idx_d = drn_idx_q + RW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
      load_matrix_d = ((state_d == S_LOAD1) &&  mat_first) || ((state_d == S_LOAD2) && !mat_first);
      load_vector_d = ((state_d == S_LOAD1) && !mat_first) || ((state_d == S_LOAD2) &&  mat_first);
      start_d       = (state_d == S_START);
   end

   // Control and core-side output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         mode_q        <= 2'd0;
         wr_cnt_q      <= '0;
         rd_idx_q      <= '0;
         wait_cnt_q    <= '0;
         cap_cnt_q     <= '0;
         drn_idx_q     <= '0;
         load_matrix_q <= 1'b0;
         load_vector_q <= 1'b0;
         start_q       <= 1'b0;
         err_q         <= 1'b0;
         data_in_q     <= '0;
      end else begin
         state_q       <= state_d;
         mode_q        <= mode_d;
         wr_cnt_q      <= wr_cnt_d;
         rd_idx_q      <= rd_idx_d;
         wait_cnt_q    <= wait_cnt_d;
         cap_cnt_q     <= cap_cnt_d;
         drn_idx_q     <= drn_idx_d;
         load_matrix_q <= load_matrix_d;
         load_vector_q <= load_vector_d;
         start_q       <= start_d;
         err_q         <= err_d;
         data_in_q     <= data_in_d;
      end
   end

   // Operand staging and result capture storage.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NW; i++) stage_q[i] <= '0;
         for (int i = 0; i < k; i++)  res_buf_q[i] <= '0;
      end else begin
         if (stage_we) stage_q[wr_cnt_q] <= in_data;
         if (res_we)   res_buf_q[cap_cnt_q] <= data_out;
      end
   end

   assign cmd_ready  = (state_q == S_IDLE);
   assign in_ready   = (state_q == S_FILL);
   assign busy       = (state_q != S_IDLE);
   assign loadMatrix = load_matrix_q;
   assign loadVector = load_vector_q;
   assign start      = start_q;
   assign data_in    = data_in_q;
   assign err        = err_q;
   assign res_valid  = (state_q == S_DRAIN);
   assign res_data   = (state_q == S_DRAIN) ? res_buf_q[drn_idx_q] : '0;
   assign res_last   = (state_q == S_DRAIN) && (drn_idx_q == R_LAST);

endmodule

// File: tb/tb_mvm_host_ctrl.sv
// tb_mvm_host_ctrl: directed bench for mvm_host_ctrl with a behavioural
// mvm_k_b core model driven on the falling edge.
module tb_mvm_host_ctrl;
   localparam int K   = 8;
   localparam int B   = 8;
   localparam int TMO = 4096;

   logic                  clk = 1'b0;
   logic                  reset, cmd_valid, cmd_ready, in_valid, in_ready;
   logic [1:0]            cmd_mode;
   logic signed [B-1:0]   in_data, data_in;
   logic                  loadMatrix, loadVector, start, done;
   logic signed [2*B-1:0] data_out, res_data;
   logic                  res_valid, res_ready, res_last, busy, err;

   mvm_host_ctrl #(.k(K), .b(B), .timeout(TMO)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_mode(cmd_mode), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .loadMatrix(loadMatrix), .loadVector(loadVector), .start(start), .data_in(data_in),
      .done(done), .data_out(data_out), .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_last(res_last), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Core model state and event monitors
   logic signed [B-1:0]   mat [K*K];
   logic signed [B-1:0]   vec [K];
   logic signed [2*B-1:0] y [K];
   int  m_idx, v_idx, o_idx, d_cnt, acc;
   bit  m_act, v_act, o_act;
   int  lm_n = 0, lv_n = 0, st_n = 0, err_n = 0, rv_n = 0, dz_bad = 0;
   int  lm_cyc = 0, lv_cyc = 0, st_cyc = 0, err_cyc = 0;
   int  spur_req_n = 0, spur_ack_n = 0;
   bit  no_done = 1'b0;

   initial begin
      done = 1'b0; data_out = '0;
      m_act = 0; v_act = 0; o_act = 0; d_cnt = 0; m_idx = 0; v_idx = 0; o_idx = 0;
      for (int i = 0; i < K*K; i++) mat[i] = '0;
      for (int i = 0; i < K; i++) begin vec[i] = '0; y[i] = '0; end
      forever begin
         @(negedge clk);
         if (reset) begin
            m_act = 0; v_act = 0; o_act = 0; d_cnt = 0;
            done = 1'b0; data_out = '0;
         end else begin
            if (!m_act && !v_act && data_in != '0) dz_bad++;
            if (loadMatrix) begin
               lm_n++; lm_cyc = cyc; m_act = 1; m_idx = 0;
            end else if (m_act) begin
               mat[m_idx] = data_in; m_idx++;
               if (m_idx == K*K) m_act = 0;
            end
            if (loadVector) begin
               lv_n++; lv_cyc = cyc; v_act = 1; v_idx = 0;
            end else if (v_act) begin
               vec[v_idx] = data_in; v_idx++;
               if (v_idx == K) v_act = 0;
            end
            if (start) begin
               st_n++; st_cyc = cyc;
               for (int i = 0; i < K; i++) begin
                  acc = 0;
                  for (int j = 0; j < K; j++) acc += int'(mat[i*K+j]) * int'(vec[j]);
                  y[i] = acc[2*B-1:0];
               end
               if (!no_done) d_cnt = 4;
            end
            if (err) begin err_n++; err_cyc = cyc; end
            if (res_valid) rv_n++;
            done = 1'b0; data_out = '0;
            if (spur_req_n != spur_ack_n) begin spur_ack_n = spur_req_n; done = 1'b1; end
            if (d_cnt > 0) begin
               d_cnt--;
               if (d_cnt == 0) begin done = 1'b1; o_act = 1; o_idx = 0; end
            end else if (o_act) begin
               data_out = y[o_idx]; o_idx++;
               if (o_idx == K) o_act = 0;
            end
         end
      end
   end

   int n_chk = 0, n_fail = 0;

   task automatic check_val(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   logic signed [B-1:0]   stim [K*K+K];
   logic signed [2*B-1:0] got_res [K];
   int exp_res [K];
   int got_n, n_last, last_pos, acc_cyc, lm0, lv0, st0, err0, rv0;

   task automatic snap();
      lm0 = lm_n; lv0 = lv_n; st0 = st_n; err0 = err_n; rv0 = rv_n;
   endtask

   task automatic check_results(input string tag);
      check_val({tag, "_count"}, got_n, K);
      check_val({tag, "_last_pos"}, last_pos, K);
      check_val({tag, "_last_n"}, n_last, 1);
      for (int i = 0; i < K; i++) check_val($sformatf("%s_res%0d", tag, i), got_res[i], exp_res[i]);
   endtask

   task automatic load_identity(input int v0, input int step);
      for (int i = 0; i < K*K; i++) stim[i] = ((i / K) == (i % K)) ? 8'sd1 : 8'sd0;
      for (int i = 0; i < K; i++) begin
         stim[K*K+i] = 8'(v0 + step*i);
         exp_res[i]  = v0 + step*i;
      end
   endtask

   task automatic do_cmd(input int mode, input int nw, input bit gap, input bit rtog,
                         input bit spur, input bit expect_res, input bit rst_mid);
      int  sent, guard;
      bit  ph, spur_f, fin;
      sent = 0; ph = 0; spur_f = 0; got_n = 0; n_last = 0; last_pos = -1;
      snap();
      @(negedge clk);
      cmd_valid = 1'b1; cmd_mode = 2'(mode);
      check_val("cmd_ready_idle", cmd_ready, 1);
      acc_cyc = cyc;
      @(negedge clk);
      cmd_valid = 1'b0;
      guard = 0;
      while (sent < nw && guard < 1000) begin
         if (gap && ph) in_valid = 1'b0;
         else begin in_valid = 1'b1; in_data = stim[sent]; end
         ph = !ph;
         if (spur && !spur_f && sent == 10) begin spur_req_n++; spur_f = 1; end
         if (in_valid && in_ready) sent++;
         @(negedge clk);
         guard++;
      end
      in_valid = 1'b0; in_data = '0;
      check_val("fill_count", sent, nw);
      if (rst_mid) begin
         guard = 0;
         while (lm_n == lm0 && guard < 200) begin @(negedge clk); guard++; end
         check_val("rst_reach_stream", lm_n - lm0, 1);
         repeat (10) @(negedge clk);
         reset = 1'b1;
         @(negedge clk);
         check_val("rst_loadMatrix", loadMatrix, 0);
         check_val("rst_loadVector", loadVector, 0);
         check_val("rst_start", start, 0);
         check_val("rst_data_in", data_in, 0);
         check_val("rst_busy", busy, 0);
         check_val("rst_cmd_ready", cmd_ready, 1);
         @(negedge clk);
         reset = 1'b0;
         return;
      end
      fin = 0; guard = 0;
      while (!fin && guard < 6000) begin
         res_ready = rtog ? ph : 1'b1;
         ph = !ph;
         if (res_valid && res_ready) begin
            if (got_n < K) got_res[got_n] = res_data;
            got_n++;
            if (res_last) begin n_last++; last_pos = got_n; fin = 1; end
         end
         if (!expect_res && err) fin = 1;
         @(negedge clk);
         guard++;
      end
      res_ready = 1'b0;
      check_val("cmd_complete", fin, 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; cmd_valid = 1'b0; cmd_mode = 2'd0; in_valid = 1'b0;
      in_data = '0; res_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_val("rst_cmd_ready0", cmd_ready, 1);
      check_val("rst_busy0", busy, 0);
      check_val("rst_in_ready0", in_ready, 0);
      check_val("rst_pulses0", {loadMatrix, loadVector, start, err}, 0);
      check_val("rst_data_in0", data_in, 0);
      check_val("rst_res0", {res_valid, res_last}, 0);
      check_val("rst_res_data0", res_data, 0);
      reset = 1'b0;

      // Mode 0: identity matrix, vector 1..8
      load_identity(1, 1);
      do_cmd(0, K*K+K, 0, 0, 0, 1, 0);
      check_val("m0_lm_pulses", lm_n - lm0, 1);
      check_val("m0_lv_pulses", lv_n - lv0, 1);
      check_val("m0_lv_gap", lv_cyc - lm_cyc, K*K+1);
      check_val("m0_st_gap", st_cyc - lv_cyc, K+1);
      check_val("m0_latency", st_cyc - acc_cyc, (K*K+K) + 1 + K*K + 1 + K + 1);
      check_results("m0");

      // Mode 2: all-2 matrix, vector 1..8 retained -> 2*36
      for (int i = 0; i < K*K; i++) stim[i] = 8'sd2;
      for (int i = 0; i < K; i++) exp_res[i] = 72;
      do_cmd(2, K*K, 0, 0, 0, 1, 0);
      check_val("m2_lm_pulses", lm_n - lm0, 1);
      check_val("m2_lv_pulses", lv_n - lv0, 0);
      check_val("m2_st_gap", st_cyc - lm_cyc, K*K+1);
      check_results("m2");

      // Mode 3: all -1 vector against retained all-2 matrix
      for (int i = 0; i < K; i++) begin stim[i] = -8'sd1; exp_res[i] = -16; end
      do_cmd(3, K, 0, 0, 0, 1, 0);
      check_val("m3_lm_pulses", lm_n - lm0, 0);
      check_val("m3_lv_pulses", lv_n - lv0, 1);
      check_val("m3_st_gap", st_cyc - lv_cyc, K+1);
      check_results("m3");

      // Mode 0 with input gaps and a toggling result consumer
      for (int i = 0; i < K*K; i++) stim[i] = ((i / K) == (i % K)) ? 8'sd1 : 8'sd0;
      stim[K*K+0] = -8'sd5;   exp_res[0] = -5;
      stim[K*K+1] = 8'sd7;    exp_res[1] = 7;
      stim[K*K+2] = -8'sd128; exp_res[2] = -128;
      stim[K*K+3] = 8'sd127;  exp_res[3] = 127;
      stim[K*K+4] = 8'sd0;    exp_res[4] = 0;
      stim[K*K+5] = 8'sd1;    exp_res[5] = 1;
      stim[K*K+6] = -8'sd1;   exp_res[6] = -1;
      stim[K*K+7] = 8'sd100;  exp_res[7] = 100;
      do_cmd(0, K*K+K, 1, 1, 0, 1, 0);
      check_val("gap_lv_gap", lv_cyc - lm_cyc, K*K+1);
      check_val("gap_st_gap", st_cyc - lv_cyc, K+1);
      check_results("gap");

      // Timeout: the core never answers
      no_done = 1'b1;
      for (int i = 0; i < K; i++) stim[i] = 8'sd1;
      do_cmd(3, K, 0, 0, 0, 0, 0);
      no_done = 1'b0;
      check_val("tmo_err_delay", err_cyc - st_cyc, TMO);
      check_val("tmo_err_pulses", err_n - err0, 1);
      check_val("tmo_no_results", rv_n - rv0, 0);
      check_val("tmo_cmd_ready", cmd_ready, 1);
      check_val("tmo_busy", busy, 0);
      check_val("tmo_err_low", err, 0);

      // Reset during STREAM1, then a clean mode 0 command with vector 8..1
      load_identity(1, 1);
      do_cmd(0, K*K+K, 0, 0, 0, 1, 1);
      load_identity(8, -1);
      do_cmd(0, K*K+K, 0, 0, 0, 1, 0);
      check_val("post_rst_latency", st_cyc - acc_cyc, (K*K+K) + 1 + K*K + 1 + K + 1);
      check_results("post_rst");

      // Spurious done during FILL must be ignored
      load_identity(1, 1);
      do_cmd(0, K*K+K, 0, 0, 1, 1, 0);
      check_val("spur_issued", spur_ack_n, spur_req_n);
      check_val("spur_start_pulses", st_n - st0, 1);
      check_results("spur");

      check_val("data_in_idle_zero", dz_bad, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/mvm_host_ctrl.md
Name: mvm_host_ctrl

Overview:
- Hardware host-side initiator for the mvm_k_b matrix-vector core's load/start/done protocol; it replaces bench-driven stimulus in system builds.
- Accepts a command plus a stream of operand words over valid/ready, stages them, and replays them to the core as gap-free bursts.
- Pulses start, waits for done, captures the k serial results, and returns them over a valid/ready result stream.

Parameters:
k, 8, matrix dimension; matrix k*k words, vector k words, k results.
b, 8, operand width; results are 2*b.
timeout, 4096, max cycles in WAIT_DONE before abort.

Ports:
clk  in  1  clock; all logic on posedge.
reset  in  1  synchronous, active-high reset.
cmd_valid  in  1  command offered.
cmd_ready  out  1  high only in IDLE.
cmd_mode  in  2  0: matrix then vector; 1: vector then matrix; 2: matrix only; 3: vector only.
in_valid  in  1  operand word offered.
in_ready  out  1  high only in FILL.
in_data  in  b  signed operand word, in core load order.
loadMatrix  out  1  one-cycle pulse to core.
loadVector  out  1  one-cycle pulse to core.
start  out  1  one-cycle pulse to core.
data_in  out  b  signed word to core.
done  in  1  core completion.
data_out  in  2*b  signed core result.
res_valid  out  1  result word available.
res_ready  in  1  result consumer ready.
res_data  out  2*b  signed result word.
res_last  out  1  high with the k-th result.
busy  out  1  high in any state other than IDLE.
err  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset values: all outputs 0, except that cmd_ready is 1. FSM goes to IDLE; counters, staging and result buffers are cleared. Reset mid-operation aborts with no further core pulses.
- Word count N is set by mode: k*k+k for modes 0 and 1, k*k for mode 2, k for mode 3.
- Staging RAM holds k*k+k words of b bits. Result buffer holds k words of 2*b bits.
- IDLE: on cmd_valid, latch the mode and go to FILL.
- FILL: each in_valid cycle writes one word; in_valid low stalls without penalty. After the N-th word, go to LOAD1 on the next cycle.
- LOAD1: pulse loadMatrix (modes 0, 2) or loadVector (modes 1, 3) for exactly one cycle.
- STREAM1: data_in carries staged words 0 .. N1-1 on consecutive cycles with no bubbles. N1 is k*k for modes 0 and 2, k for modes 1 and 3.
- Modes 0 and 1 then continue through LOAD2 and STREAM2:
  - LOAD2 is the one-cycle pulse of the other load signal, on the cycle immediately after the last STREAM1 word.
  - STREAM2 streams the remaining words back-to-back.
- Modes 2 and 3 skip LOAD2 and STREAM2. The core retains its other operand from earlier commands.
- data_in is 0 outside STREAM states.
- START: one-cycle start pulse on the cycle after the last streamed word, then go to WAIT_DONE.
- WAIT_DONE: on done=1, go to CAPTURE. If done is still 0 after timeout cycles, pulse err, then go to IDLE with no results.
- done is ignored in every state except WAIT_DONE.
- CAPTURE: sample data_out on the k cycles immediately following the cycle in which done was seen, one word per cycle, with no stalls. Then go to DRAIN.
- DRAIN: res_valid=1 and res_data = buffer[idx]. idx advances on res_valid&&res_ready. res_last=1 when idx=k-1; the handshake on that word returns the FSM to IDLE.
- Result words appear in the order the core emits them.
- Handshake rules: no combinational path from res_ready or in_valid to any core-side output. Core-side outputs are registered.
- Minimum command latency for mode 0, from cmd accept to start pulse: N fill cycles + 1 + k*k + 1 + k + 1.

Test Plan:
- Mode 0 against a behavioral core, k=8: identity matrix, vector 1..8 -> one loadMatrix pulse, 64 data cycles, loadVector immediately after, 8 data cycles, start; res_data 1..8 with res_last on 8.
- Mode 2 with all-2 matrix, then mode 3 with all -1 vector -> second command's results all -16; only loadVector pulses during the second command.
- FILL with in_valid low every other cycle, and DRAIN with res_ready toggling -> core bursts remain gap-free; no result is lost or duplicated.
- Core model never asserts done -> err pulses exactly timeout cycles after start; FSM returns to IDLE with cmd_ready=1; no res_valid.
- reset asserted during STREAM1 -> next cycle: all pulses 0, data_in=0, busy=0; a following mode 0 command completes correctly.
- Spurious done pulse during FILL -> ignored; results are taken only after the real done.
